// File: rtl/shifter_pipe.sv
// Pipelined multi-mode barrel shifter: one register stage per power-of-two
// step, with a combinational valid/ready chain for full backpressure.
module shifter_pipe #(
  parameter int N     = 3,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2**N-1:0]    a,
  input  logic [N-1:0]       amt,
  input  logic [2:0]         mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2**N-1:0]    y,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W = 2**N;

  localparam logic [2:0] M_ROR = 3'b000;
  localparam logic [2:0] M_ROL = 3'b001;
  localparam logic [2:0] M_SLL = 3'b010;
  localparam logic [2:0] M_SRL = 3'b011;
  localparam logic [2:0] M_SRA = 3'b100;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [N-1:0]     amt;
    logic [2:0]       mode;
    logic [TAG_W-1:0] tag;
    logic             sgn;
  } stg_t;

  function automatic logic [W-1:0] f_step(
    input logic [W-1:0] d,
    input logic [2:0]   m,
    input logic         sgn,
    input int           s
  );
    logic [W-1:0] r;
    r = d;
    case (m)
      M_ROR:   r = (d >> s) | (d << (W - s));
      M_ROL:   r = (d << s) | (d >> (W - s));
      M_SLL:   r = d << s;
      M_SRL:   r = d >> s;
      M_SRA:   r = (d >> s) | ({W{sgn}} << (W - s));
      default: r = d;
    endcase
    return r;
  endfunction

  stg_t         r_stg [N];
  logic [N-1:0] r_vld;

  stg_t         w_src [N];
  logic [W-1:0] w_dnxt [N];
  logic [N-1:0] w_vin;
  logic [N:0]   w_rdy;

  assign w_rdy[N]  = out_ready;
  assign in_ready  = w_rdy[0];

  for (genvar k = 0; k < N; k++) begin : g_stg
    localparam int S = 1 << k;
    if (k == 0) begin : g_first
      // sign bit is frozen here so later SRA stages fill from the operand MSB
      assign w_src[k] = '{data: a, amt: amt, mode: mode,
                          tag: in_tag, sgn: a[W-1]};
      assign w_vin[k] = in_valid;
    end else begin : g_rest
      assign w_src[k] = r_stg[k-1];
      assign w_vin[k] = r_vld[k-1];
    end
    assign w_rdy[k]  = ~r_vld[k] | w_rdy[k+1];
    assign w_dnxt[k] = w_src[k].amt[k]
                     ? f_step(w_src[k].data, w_src[k].mode,
                              w_src[k].sgn, S)
                     : w_src[k].data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < N; k++) r_stg[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_rdy[k]) begin
          r_vld[k]      <= w_vin[k];
          r_stg[k]      <= w_src[k];
          r_stg[k].data <= w_dnxt[k];
        end
      end
    end
  end

  assign out_valid = r_vld[N-1];
  assign y         = r_stg[N-1].data;
  assign out_tag   = r_stg[N-1].tag;

endmodule

// File: tb/tb_shifter_pipe.sv
// Randomized and directed bench for shifter_pipe against a bitwise
// reference model with an in-order scoreboard.
module tb_shifter_pipe;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [N-1:0]  amt = '0;
  logic [2:0]    mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  y;
  logic [TW-1:0] out_tag;

  shifter_pipe #(.N(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .amt(amt), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic bp_rand = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(
    logic [W-1:0] va, int sh, logic [2:0] m
  );
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (m)
        3'd0:    r[i] = va[(i + sh) % W];
        3'd1:    r[i] = va[(i - sh + W) % W];
        3'd2:    r[i] = (i >= sh) ? va[i - sh] : 1'b0;
        3'd3:    r[i] = (i + sh < W) ? va[i + sh] : 1'b0;
        3'd4:    r[i] = (i + sh < W) ? va[i + sh] : va[W-1];
        default: r[i] = va[i];
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [W-1:0]  y;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            acc_cyc[$];
  int            xfer_cyc[$];
  logic          hold = 1'b0;
  logic [W-1:0]  hy;
  logic [TW-1:0] ht;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", y, hy);
        check("hold_tag", out_tag, ht);
      end
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (q.size() == 0) begin
          check("spurious", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("sb_y", y, e.y);
          check("sb_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        q.push_back('{model(a, int'(amt), mode), in_tag});
      end
      hold = out_valid && !out_ready;
      hy   = y;
      ht   = out_tag;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Entered and left just after a rising edge.
  task automatic send(logic [W-1:0] va, logic [N-1:0] vamt,
                      logic [2:0] vm, logic [TW-1:0] vt);
    a = va; amt = vamt; mode = vm; in_tag = vt;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", in_ready, 1);
  endtask

  task automatic single_op(logic [W-1:0] va, logic [N-1:0] vamt,
                           logic [2:0] vm, logic [TW-1:0] vt,
                           logic [W-1:0] exp_y, string nm);
    int n;
    send(va, vamt, vm, vt);
    in_valid = 1'b0;
    n = 1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_lat"}, n, 3);
    check({nm, "_y"}, y, exp_y);
    check({nm, "_tag"}, out_tag, vt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_tag", out_tag, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    single_op(8'hB4, 3'd3, 3'd0, 4'h1, 8'h96, "ror");
    single_op(8'hB4, 3'd3, 3'd1, 4'h2, 8'hA5, "rol");
    single_op(8'hB4, 3'd2, 3'd2, 4'h3, 8'hD0, "sll");
    single_op(8'hB4, 3'd2, 3'd3, 4'h4, 8'h2D, "srl");
    single_op(8'hB4, 3'd2, 3'd4, 4'h5, 8'hED, "sra_neg");
    single_op(8'h34, 3'd2, 3'd4, 4'h6, 8'h0D, "sra_pos");
    single_op(8'h5A, 3'd5, 3'd6, 4'h7, 8'h5A, "reserved");
    for (int i = 0; i < 16; i++)
      single_op(8'hB4, 3'd0, 3'(i), 4'(i), 8'hB4, "amt0");

    // back-to-back
    acc_cyc.delete();
    xfer_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 3'($urandom), 3'($urandom_range(0, 4)), 4'(i));
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_count", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8 && acc_cyc.size() == 8)
      for (int i = 0; i < 8; i++) begin
        check("b2b_acc_cyc", acc_cyc[i], acc_cyc[0] + i);
        check("b2b_out_cyc", xfer_cyc[i], acc_cyc[0] + 3 + i);
      end

    // backpressure
    out_ready = 1'b0;
    acc_cyc.delete();
    xfer_cyc.delete();
    for (int i = 0; i < 3; i++)
      send(8'($urandom), 3'($urandom), 3'($urandom_range(0, 4)), 4'(8 + i));
    a = 8'hC3; amt = 3'd1; mode = 3'd4; in_tag = 4'hB;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc_cyc.size(), 3);
    out_ready = 1'b1;
    send(8'hC3, 3'd1, 3'd4, 4'hB);
    send(8'h81, 3'd7, 3'd1, 4'hC);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("bp_delivered", xfer_cyc.size(), 5);
    check("bp_drained", q.size(), 0);

    // reset with ops in flight
    send(8'hFF, 3'd1, 3'd0, 4'hD);
    send(8'hF0, 3'd2, 3'd0, 4'hE);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_tag", out_tag, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stale", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // randomized traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(8'($urandom), 3'($urandom), 3'($urandom), 4'($urandom));
    end
    in_valid = 1'b0;
    bp_rand = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_drained", q.size(), 0);
    check("rand_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
